// File: rtl/eth_pkg.sv
// eth_pkg: shared constants, state encoding and error codes for the RX frame fetch sequencer
package eth_pkg;
  localparam int ETH_MTU = 1536;
  localparam int RXSIZE_OFS = 8;
  localparam int HOSTRX_OFS = 12;
  localparam int IDX_W = $clog2(ETH_MTU / 4 + 1);
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LOCK = 2'd1;
  localparam logic [1:0] ERR_SIZE = 2'd2;
  localparam logic [1:0] ERR_SLV = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_LOCK_W, S_LOCK_RB, S_GAP, S_SIZE_R, S_DATA_R, S_OUT, S_UNLOCK_W, S_FIN
  } state_t;
  function automatic logic [3:0] last_keep(input logic [1:0] len_lsb);
    return len_lsb == 2'd0 ? 4'b1111 : ~(4'b1111 >> len_lsb);
  endfunction
endpackage

// File: rtl/eth_apb_master.sv
// eth_apb_master: single-access APB engine; SETUP, ACCESS until pready, then a forced idle cycle
module eth_apb_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        slverr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS, A_GAP} apb_st_t;
  apb_st_t st;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= A_IDLE;
      ack <= 1'b0;
      rdata <= '0;
      slverr <= 1'b0;
      psel <= 1'b0;
      penable <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
    end else begin
      ack <= 1'b0;
      case (st)
        A_IDLE: if (req) begin
          st <= A_SETUP;
          psel <= 1'b1;
          pwrite <= wr;
          paddr <= addr;
          pwdata <= wdata;
        end
        A_SETUP: begin
          st <= A_ACCESS;
          penable <= 1'b1;
        end
        A_ACCESS: if (pready) begin
          st <= A_GAP;
          psel <= 1'b0;
          penable <= 1'b0;
          ack <= 1'b1;
          rdata <= prdata;
          slverr <= pslverr;
        end
        default: st <= A_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/eth_rx_fetch_ctrl.sv
// eth_rx_fetch_ctrl: locks the ethernet RX buffer over APB, streams one frame out, then unlocks
module eth_rx_fetch_ctrl
  import eth_pkg::*;
#(
  parameter int RETRY_GAP = 64,
  parameter int MAX_RETRY = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_len,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [3:0]  m_keep
);
  state_t st;
  logic [7:0] retry;
  logic [15:0] gap_cnt;
  logic [IDX_W-1:0] idx, nwords;
  logic req, wr, ack, slverr, is_last, size_bad;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  assign req = st inside {S_LOCK_W, S_LOCK_RB, S_SIZE_R, S_DATA_R, S_UNLOCK_W};
  assign wr = st == S_LOCK_W || st == S_UNLOCK_W;
  assign wdata = {31'd0, st == S_LOCK_W};
  assign addr = st == S_DATA_R ? 16'({idx, 2'b00}) :
                st == S_SIZE_R ? 16'(ETH_MTU + RXSIZE_OFS) : 16'(ETH_MTU + HOSTRX_OFS);
  assign is_last = idx == nwords - IDX_W'(1);
  assign size_bad = rdata[15:0] == 16'd0 || rdata[15:0] > 16'(ETH_MTU);
  eth_apb_master u_apb (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .slverr(slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  // GAP is shortened by the two bus-idle cycles around it so the bus sees exactly RETRY_GAP idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      frame_len <= '0;
      retry <= '0;
      gap_cnt <= '0;
      idx <= '0;
      nwords <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      m_keep <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (st)
        S_IDLE: if (start) begin
          busy <= 1'b1;
          err_code <= ERR_NONE;
          retry <= '0;
          st <= S_LOCK_W;
        end
        S_LOCK_W: if (ack) begin
          err_code <= slverr ? ERR_SLV : err_code;
          st <= slverr ? S_FIN : S_LOCK_RB;
        end
        S_LOCK_RB: if (ack) begin
          if (slverr) begin
            err_code <= ERR_SLV;
            st <= S_FIN;
          end else if (rdata[0]) begin
            st <= S_SIZE_R;
          end else begin
            retry <= retry + 8'd1;
            gap_cnt <= '0;
            err_code <= retry + 8'd1 == 8'(MAX_RETRY) ? ERR_LOCK : err_code;
            st <= retry + 8'd1 == 8'(MAX_RETRY) ? S_FIN : S_GAP;
          end
        end
        S_GAP: begin
          gap_cnt <= gap_cnt + 16'd1;
          if (gap_cnt == 16'(RETRY_GAP - 3)) st <= S_LOCK_W;
        end
        S_SIZE_R: if (ack) begin
          if (slverr) begin
            err_code <= ERR_SLV;
            st <= S_UNLOCK_W;
          end else begin
            frame_len <= rdata[15:0];
            idx <= '0;
            nwords <= IDX_W'((rdata[15:0] + 16'd3) >> 2);
            err_code <= size_bad ? ERR_SIZE : err_code;
            st <= size_bad ? S_UNLOCK_W : S_DATA_R;
          end
        end
        S_DATA_R: if (ack) begin
          if (slverr) begin
            err_code <= ERR_SLV;
            st <= S_UNLOCK_W;
          end else begin
            m_valid <= 1'b1;
            m_data <= rdata;
            m_last <= is_last;
            m_keep <= is_last ? last_keep(frame_len[1:0]) : 4'b1111;
            st <= S_OUT;
          end
        end
        S_OUT: if (m_ready) begin
          m_valid <= 1'b0;
          m_last <= 1'b0;
          idx <= idx + IDX_W'(1);
          st <= m_last ? S_UNLOCK_W : S_DATA_R;
        end
        S_UNLOCK_W: if (ack) st <= S_FIN;
        S_FIN: begin
          busy <= 1'b0;
          done <= err_code == ERR_NONE;
          err <= err_code != ERR_NONE;
          st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_fetch_ctrl.sv
// tb_eth_rx_fetch_ctrl: directed and random frame fetches against an APB slave model and a transaction-level reference
module tb_eth_rx_fetch_ctrl;
  localparam int MTU = 1536;
  localparam int RG = 64;
  localparam int MR = 16;
  localparam logic [15:0] HOST = 16'(MTU + 12);
  localparam logic [15:0] SIZE = 16'(MTU + 8);
  typedef struct {bit wr; logic [15:0] a; logic [31:0] d; int s; int c;} tr_t;
  typedef struct {bit wr; logic [15:0] a; logic [31:0] d;} ex_t;
  typedef struct {logic [31:0] d; logic l; logic [3:0] k;} w_t;
  logic clk, rst_n, start, busy, done, err, psel, penable, pwrite, pready, pslverr;
  logic m_valid, m_ready, m_last;
  logic [1:0] err_code;
  logic [15:0] frame_len, paddr;
  logic [31:0] pwdata, prdata, m_data, rxsize, stall_ref;
  logic [3:0] m_keep;
  logic [109:0] all_out;
  logic [31:0] mem [384];
  tr_t tr[$];
  w_t words[$];
  int n_assert = 0, n_fail = 0, cyc = 0, attempts = 0, fail_n = 0, err_word = -1, wcnt = 0;
  int stall_left = 0, stall_word = 0, done_cnt = 0, err_cnt = 0, exp_fl = 0, setup_cyc = 0;
  bit rnd_ready = 0, rnd_wait = 0, stall_en = 0, stall_done = 0;
  eth_rx_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .frame_len(frame_len), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_keep(m_keep)
  );
  assign all_out = {psel, penable, pwrite, paddr, pwdata, busy, done, err, err_code,
                    frame_len, m_valid, m_last, m_data, m_keep};
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // APB slave: lock granted once more than fail_n lock writes have arrived
  initial begin pready = 0; pslverr = 0; prdata = 0; end
  always @(negedge clk) begin
    pready = 0;
    pslverr = 0;
    if (psel && !penable) setup_cyc = cyc;
    if (psel && penable) begin
      if (wcnt != 0) wcnt--;
      else begin
        pready = 1;
        if (pwrite && paddr == HOST && pwdata[0]) attempts++;
        prdata = paddr == SIZE ? rxsize : paddr == HOST ? 32'(attempts > fail_n) :
                 int'(paddr) < MTU ? mem[paddr[15:2]] : $urandom;
        pslverr = !pwrite && int'(paddr) < MTU && int'(paddr[15:2]) == err_word;
        tr.push_back('{pwrite, paddr, pwrite ? pwdata : 32'd0, setup_cyc, cyc});
        wcnt = rnd_wait ? $urandom_range(0, 2) : 0;
      end
    end
  end
  // stream sink, stall injector and pulse counters
  initial m_ready = 0;
  always @(negedge clk) begin
    if (stall_left > 0) begin
      check("stall m_data stable", m_data, stall_ref);
      check("stall no apb", psel, 0);
      stall_left--;
    end else if (stall_en && !stall_done && m_valid && words.size() == stall_word) begin
      stall_left = 10;
      stall_ref = m_data;
      stall_done = 1;
    end
    m_ready = stall_left > 0 ? 1'b0 : rnd_ready ? 1'($urandom_range(0, 3) != 0) : 1'b1;
    if (m_valid && m_ready) words.push_back('{m_data, m_last, m_keep});
    if (done) done_cnt++;
    if (err) err_cnt++;
  end
  task automatic fill();
    for (int i = 0; i < 384; i++) mem[i] = $urandom;
  endtask
  task automatic run(input int size, input int fn, input int errw);
    ex_t ex[$];
    w_t ew[$];
    bit granted;
    int att, nw, rem, n;
    logic [1:0] ec;
    granted = fn < MR;
    att = granted ? fn + 1 : MR;
    ec = granted ? 2'd0 : 2'd1;
    for (int k = 0; k < att; k++) begin
      ex.push_back('{1'b1, HOST, 32'd1});
      ex.push_back('{1'b0, HOST, 32'd0});
    end
    if (granted) begin
      exp_fl = size & 'hffff;
      ex.push_back('{1'b0, SIZE, 32'd0});
      if (size == 0 || size > MTU) ec = 2;
      else begin
        nw = (size + 3) / 4;
        rem = size - 4 * (nw - 1);
        for (int i = 0; i < nw; i++) begin
          ex.push_back('{1'b0, 16'(4 * i), 32'd0});
          if (i == errw) begin ec = 3; break; end
          ew.push_back('{mem[i], i == nw - 1, i == nw - 1 ? 4'((15 << (4 - rem)) & 15) : 4'hf});
        end
      end
      ex.push_back('{1'b1, HOST, 32'd0});
    end
    fail_n = fn; rxsize = size; err_word = errw; attempts = 0;
    tr.delete(); words.delete(); done_cnt = 0; err_cnt = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    check("busy after start", busy, 1);
    n = 0;
    while (done_cnt + err_cnt == 0 && n < 6000) begin @(negedge clk); n++; end
    check("finished within budget", done_cnt + err_cnt != 0, 1);
    repeat (5) @(negedge clk);
    check("done pulses", done_cnt, ec == 0 ? 1 : 0);
    check("err pulses", err_cnt, ec == 0 ? 0 : 1);
    check("err_code", err_code, ec);
    check("busy after finish", busy, 0);
    check("frame_len", frame_len, exp_fl);
    check("apb access count", tr.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      if (i < tr.size()) check("apb access", {tr[i].wr, tr[i].a, tr[i].d}, {ex[i].wr, ex[i].a, ex[i].d});
    for (int k = 0; k + 1 < att; k++)
      if (2 * k + 2 < tr.size()) check("retry idle gap", tr[2 * k + 2].s - tr[2 * k + 1].c - 1, RG);
    check("stream word count", words.size(), ew.size());
    for (int i = 0; i < ew.size(); i++)
      if (i < words.size()) check("stream word", {words[i].d, words[i].l, words[i].k}, {ew[i].d, ew[i].l, ew[i].k});
  endtask
  initial begin
    int n;
    rst_n = 0;
    start = 0;
    rxsize = 0;
    fill();
    repeat (3) @(negedge clk);
    check("reset outputs", all_out, 0);
    rst_n = 1;
    @(negedge clk);
    run(64, 0, -1);
    fill();
    mem[0] = 32'h11223344;
    mem[1] = {8'h55, 24'($urandom)};
    run(5, 0, -1);
    if (words.size() > 1) check("5-byte tail word", {words[1].d[31:24], words[1].l, words[1].k}, {8'h55, 1'b1, 4'b1000});
    run(20, 3, -1);
    run(64, 100, -1);
    run(0, 0, -1);
    run(1537, 0, -1);
    stall_en = 1; stall_done = 0; stall_word = 5;
    run(64, 0, -1);
    check("stall exercised", stall_done, 1);
    stall_en = 0;
    fill();
    run(64, 0, 3);
    fill();
    fail_n = 0; rxsize = 64; err_word = -1; attempts = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (!(psel && int'(paddr) < MTU) && n < 3000) begin @(negedge clk); n++; end
    check("reached data read", psel, 1);
    rst_n = 0;
    @(negedge clk);
    check("outputs after mid-frame reset", all_out, 0);
    rst_n = 1;
    exp_fl = 0;
    @(negedge clk);
    run(12, 0, -1);
    run(MTU, 0, -1);
    rnd_ready = 1;
    rnd_wait = 1;
    for (int i = 0; i < 4; i++) begin
      fill();
      run($urandom_range(1, 200), $urandom_range(0, 2), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_rx_fetch_ctrl.md
Name: eth_rx_fetch_ctrl

Overview:
- APB-master sequencer that pulls one received frame out of the ethernet block's RX buffer on request.
- Sits between a CSR-driven start pulse and the ethernet APB slave port.
- Locks the RX buffer (hostrx), reads the frame size, reads the frame word by word, streams the words out with last/keep, then unlocks.
- Reports done or error with an error code.

Parameters:
- ETH_MTU, 1536: RX buffer size in bytes; base of the control registers in the slave's address map.
- RETRY_GAP, 64: idle cycles between lock attempts that the slave refused.
- MAX_RETRY, 16: lock attempts allowed before a lock-timeout error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; fetch one frame
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse; frame delivered
- err  out  1  one-cycle pulse; operation aborted
- err_code  out  2  0 none, 1 lock timeout, 2 bad size, 3 slave error; held until next start
- frame_len  out  16  size read from slave; held until next start
- psel, penable, pwrite  out  1 each  APB master controls
- paddr  out  16  APB address
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready, pslverr  in  1 each  APB completion and error
- m_valid  out  1  stream word valid
- m_ready  in  1  stream word accepted
- m_data  out  32  frame bytes; lowest-offset byte in [31:24]
- m_last  out  1  final word of frame
- m_keep  out  4  valid bytes, bit3 = [31:24]

Behaviour:
- Reset (rst_n low at posedge) forces IDLE. Reset values: psel, penable, pwrite, busy, done, err, m_valid, m_last = 0; paddr, pwdata, m_data, frame_len = 0; err_code = 0; m_keep = 0. Retry and word counters also reset to 0.
- Reset mid-operation abandons the transfer immediately. It does not clean up the slave's lock. The next start rewrites hostrx=1, which the slave treats as idempotent.
- APB access sequence:
  - SETUP: psel=1, penable=0, one cycle.
  - ACCESS: penable=1, held until pready=1.
  - On the pready cycle, capture prdata and pslverr.
  - Next cycle: psel=0, penable=0. At least one idle cycle separates accesses, because the slave needs pready low before it accepts a new access.
- Register map, offsets relative to ETH_MTU:
  - +8: read rxsize.
  - +12: write hostrx (lock/unlock) and read back hostrx.
  - Address 4*i (i < ETH_MTU/4): read RX word i.
- States:
  - IDLE: start=1 sets busy, clears err_code, clears the retry count, and goes to LOCK_W. start while busy is ignored.
  - LOCK_W: write 1 to +12. Then go to LOCK_RB.
  - LOCK_RB: read +12.
    - prdata[0]=1: go to SIZE_R.
    - prdata[0]=0: retry_count+1. If the count reaches MAX_RETRY, signal err code 1 and go to FIN (no unlock). Otherwise go to GAP.
  - GAP: count RETRY_GAP cycles, then go to LOCK_W.
  - SIZE_R: read +8 and load frame_len = prdata[15:0]. If frame_len==0 or frame_len>ETH_MTU, record err code 2 and go to UNLOCK_W. Otherwise set nwords=(frame_len+3)>>2 and word index=0, and go to DATA_R.
  - DATA_R: read address 4*index and load m_data. Go to OUT.
  - OUT: m_valid=1 until the m_ready handshake completes.
    - m_last=1 when index==nwords-1.
    - m_keep=1111 except on the last word, where frame_len[1:0] gives 01→1000, 10→1100, 11→1110, 00→1111.
    - On the handshake: m_valid=0 and index+1. Go to UNLOCK_W if last, otherwise DATA_R.
  - UNLOCK_W: write 0 to +12, then go to FIN. This state is always reached once a lock has succeeded, including after error codes 2 and 3.
  - FIN: busy=0, and one cycle of done (err_code==0) or err (err_code!=0). Return to IDLE.
- pslverr=1 on any completed access records err code 3.
  - If the lock is held (after a successful LOCK_RB), go to UNLOCK_W. The unlock write's own pslverr is ignored.
  - Otherwise go to FIN.
  - The first recorded error code wins.
- The output holds one word only: no read is issued while m_valid=1. m_data, m_keep and m_last are stable while m_valid && !m_ready.
- Byte-offset arithmetic is 16-bit. index is 9 bits wide when ETH_MTU=1536.

Decomposition:
- Shared package eth_pkg holds:
  - ETH_MTU and the register offsets (RXSIZE_OFS=8, HOSTRX_OFS=12).
  - The state encoding enum.
  - The err_code constants.
- One natural sub-module, eth_apb_master: single-access APB engine with inputs req, wr, addr, wdata and outputs ack, rdata, slverr. It implements SETUP/ACCESS plus the mandatory idle cycle.

Test Plan:
- Lock granted, rxsize=64, m_ready=1 → 16 words at addresses 0..60 with m_keep=1111 and m_last on word 15. Write 0 to +12, one done pulse, frame_len=64.
- rxsize=5, slave words 0x11223344 and 0x55xxxxxx → 2 words; the second has m_keep=1000 and m_last=1; done.
- Lock readback 0 for 3 attempts then 1 → exactly RETRY_GAP idle cycles between the 4 LOCK_W writes; frame delivered; done.
- Lock readback always 0 → 16 write/read pairs, no unlock write, err pulse, err_code=1.
- rxsize=0, and separately rxsize=1537 → no data reads, unlock write, err, err_code=2.
- m_ready held low 10 cycles mid-frame → m_data stable and no APB activity during the stall.
- pslverr on data word 3 → unlock write issued, err_code=3.
- rst_n low during DATA_R → all outputs 0 on the next cycle and busy=0.
